// File: rtl/jtag_byte_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// jtag_byte_transmitter_pkg
//
// Purpose:
//   Shared definitions for the JTAG serial transmitter. This package holds:
//     - the transmitter FSM state type;
//     - the IDCODE constant that the TAP shifts out through this block;
//     - a small helper that sizes the bit counter.
//
// Ports:
//   None. This file is a package.
// -----------------------------------------------------------------------------
package jtag_byte_transmitter_pkg;

  // Transmitter FSM states.
  //   ST_IDLE  : waiting for the first enabled edge.
  //   ST_SHIFT : transfer in progress.
  //   ST_DONE  : all bits presented. Stays here until reset.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } jbt_state_e;

  // Device identification word, shifted out during Shift-DR under IDCODE.
  localparam logic [31:0] IDCODE = 32'h000F_AF01;

  // Counter width needed to hold the values 0..width inclusive.
  function automatic int jbt_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/jtag_byte_transmitter.sv
// -----------------------------------------------------------------------------
// jtag_byte_transmitter
//
// Purpose:
//   Serializes a WIDTH-bit word onto a single registered output, LSB first.
//   It advances one bit per rising clock edge while `enable` is high, and
//   raises a sticky `done` flag on the edge that presents the last bit.
//   The TAP controller uses it to drive TDO during Shift-DR while IDCODE is
//   active. To re-arm it, the controller pulses `reset`.
//
// Parameters:
//   WIDTH   number of bits serialized (must be >= 2), default 32
//
// Ports:
//   clk     input         rising-edge clock
//   reset   input         asynchronous, active-high; clears all state
//   enable  input         advance one bit per edge while high; hold when low
//   in      input [W-1:0] word to send; captured on the first enabled edge
//   out     output        registered serial data, LSB first
//   done    output        registered; high once all WIDTH bits were presented
// -----------------------------------------------------------------------------
module jtag_byte_transmitter
  import jtag_byte_transmitter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] in,
  output logic             out,
  output logic             done
);

  localparam int CW = jbt_cnt_width(WIDTH);

  // Counter value reached on the edge that presents in[WIDTH-1].
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  jbt_state_e       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             out_q;
  logic             done_q;

  // The increment is shared by the counter update and the terminal test.
  logic [CW-1:0]    cnt_inc;
  assign cnt_inc = cnt + 1'b1;

  // Single-process FSM. Every register holds while `enable` is low. The
  // paused bit therefore stays on `out`, and the next enabled edge carries
  // on with the following bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      cnt    <= '0;
      out_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          // Capture edge. Bit 0 goes straight to the output, and the
          // remaining bits are parked in the shift register. Later changes
          // on `in` therefore cannot reach this transfer.
          out_q  <= in[0];
          shreg  <= in >> 1;
          cnt    <= CW'(1);
          done_q <= 1'b0;
          state  <= ST_SHIFT;
        end

        ST_SHIFT: begin
          out_q <= shreg[0];
          shreg <= shreg >> 1;
          cnt   <= cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            // This edge puts in[WIDTH-1] on `out`, so `done` rises with it.
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Sticky. The last bit stays on `out` and `enable` is ignored
          // until reset.
          done_q <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign done = done_q;

`ifdef FORMAL
  // `done` can only fall through reset.
  always @(posedge clk) begin
    if (!reset && $past(!reset) && $past(done_q)) begin
      assert (done_q);
    end
  end

  // The counter never exceeds the word width.
  always @(posedge clk) begin
    assert (cnt <= LAST_CNT);
  end

  // The output is low on the first clock after reset.
  always @(posedge clk) begin
    if ($past(reset)) begin
      assert (!out_q);
    end
  end
`endif

endmodule

// File: tb/tb_jtag_byte_transmitter.sv
// Directed testbench for jtag_byte_transmitter (WIDTH = 32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_jtag_byte_transmitter;
  import jtag_byte_transmitter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] in;
  logic         out;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  jtag_byte_transmitter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .in     (in),
    .out    (out),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then wait 1 time unit so outputs have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs edges for bits first..last of `word`.
  // After each edge, `out` must show that bit. `done` must be high only
  // after bit W-1.
  task automatic run_bits(input logic [W-1:0] word, input int first, input int last,
                          input string tag, output logic [W-1:0] seen);
    seen = '0;
    for (int k = first; k <= last; k++) begin
      step();
      seen[k] = out;
      chk($sformatf("%s_out_b%0d", tag, k), {31'd0, out}, {31'd0, word[k]});
      chk($sformatf("%s_done_b%0d", tag, k), {31'd0, done}, {31'd0, (k == W - 1)});
    end
  endtask

  logic [W-1:0] word;
  logic [W-1:0] seen;
  logic [W-1:0] seen2;

  initial begin
    // Reset held with enable=1 and in=all ones: outputs are 0 immediately and
    // stay 0 while reset is held.
    reset  = 1'b1;
    enable = 1'b1;
    in     = 32'hFFFF_FFFF;
    #2;
    chk("rst_async_out", {31'd0, out}, 32'd0);
    chk("rst_async_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_held_out", {31'd0, out}, 32'd0);
      chk("rst_held_done", {31'd0, done}, 32'd0);
    end
    $display("reset: held %0d edges", 3);

    // Release reset with enable low. Nothing should start.
    reset  = 1'b0;
    enable = 1'b0;
    step();
    chk("idle_out", {31'd0, out}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);

    // Full IDCODE transfer. Expected LSB-first stream:
    // 1,0,0,0,0,0,0,0,1,1,1,1,0,1,0,1,1,1,1,1, then twelve 0s.
    word   = 32'h000F_AF01;
    in     = IDCODE;
    enable = 1'b1;
    run_bits(word, 0, W - 1, "idcode", seen);
    chk("idcode_stream", seen, 32'h000F_AF01);
    $display("transfer idcode: stream=%h done=%b", seen, done);

    // Done is sticky. With enable high and `in` toggling, done stays 1 and
    // out stays in[31]=0.
    for (int i = 0; i < 10; i++) begin
      in = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      step();
      chk("sticky_done", {31'd0, done}, 32'd1);
      chk("sticky_out", {31'd0, out}, 32'd0);
    end
    $display("sticky: 10 extra edges, done=%b out=%b", done, out);

    // Re-arm with a reset pulse placed between edges.
    reset = 1'b1;
    #2;
    chk("rearm_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Pause test with A5A5A5A5. After edge 7, in[6]=0 is on out.
    // Drop enable for 5 cycles.
    word = 32'hA5A5_A5A5;
    in   = word;
    run_bits(word, 0, 6, "pause_pre", seen);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pause_hold_out", {31'd0, out}, 32'd0);
      chk("pause_hold_done", {31'd0, done}, 32'd0);
    end
    enable = 1'b1;
    run_bits(word, 7, W - 1, "pause_post", seen2);
    chk("pause_stream", seen | seen2, 32'hA5A5_A5A5);
    $display("transfer pause: stream=%h done=%b", seen | seen2, done);

    // Change the input mid-transfer. Capture 12345678, then drive 0 after
    // edge 1. The serial stream must still equal 12345678.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    word  = 32'h1234_5678;
    in    = word;
    run_bits(word, 0, 0, "inchg_pre", seen);
    in = 32'h0000_0000;
    run_bits(word, 1, W - 1, "inchg_post", seen2);
    chk("inchg_stream", seen | seen2, 32'h1234_5678);
    $display("transfer inchg: stream=%h done=%b", seen | seen2, done);

    // Reset mid-transfer. Run all ones to bit 12 (out=1), then pulse reset
    // between edges. out and done must clear without a clock edge.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    word  = 32'hFFFF_FFFF;
    in    = word;
    run_bits(word, 0, 12, "midrst_pre", seen);
    reset = 1'b1;
    #2;
    chk("midrst_async_out", {31'd0, out}, 32'd0);
    chk("midrst_async_done", {31'd0, done}, 32'd0);
    #1;
    reset = 1'b0;
    // Restart with 00000003: expected stream 1,1,0,... and done after 32 edges.
    word = 32'h0000_0003;
    in   = word;
    run_bits(word, 0, W - 1, "restart", seen);
    chk("restart_stream", seen, 32'h0000_0003);
    $display("transfer restart: stream=%h done=%b", seen, done);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
